// File: rtl/two_entry_buffer.sv
// two_entry_buffer
//   Two-word circular buffer with a 1-bit head pointer and a 2-bit occupancy
//   count (0..2). The caller qualifies writes and reads; this block only
//   stores, orders and reports occupancy.
//
// Ports
//   clock       : rising-edge clock
//   clear_n     : asynchronous active-low reset (clears count, head, entries)
//   write_valid : write write_data into the tail entry on the next edge
//   write_data  : word to store
//   read_taken  : head entry consumed this cycle; head advances on the next edge
//   read_valid  : at least one entry is held
//   read_data   : head entry
//   full        : both entries are held
module two_entry_buffer #(
    parameter int WORD_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  clear_n,
    input  logic                  write_valid,
    input  logic [WORD_WIDTH-1:0] write_data,
    input  logic                  read_taken,
    output logic                  read_valid,
    output logic [WORD_WIDTH-1:0] read_data,
    output logic                  full
);

    localparam logic [1:0]            COUNT_EMPTY = 2'd0;
    localparam logic [1:0]            COUNT_ONE   = 2'd1;
    localparam logic [1:0]            COUNT_FULL  = 2'd2;
    localparam logic [WORD_WIDTH-1:0] WORD_ZERO   = '0;

    logic       head_reg;
    logic [1:0] count_reg;
    logic [1:0] count_next;
    logic       tail;

    // With one entry held the tail is the other slot; with zero or two held it
    // is the head slot (when full, a write is only issued alongside a read, so
    // the slot being vacated is the one refilled).
    assign tail = head_reg ^ (count_reg == COUNT_ONE);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            logic [WORD_WIDTH-1:0] entry_reg;

            always_ff @(posedge clock or negedge clear_n) begin
                if (!clear_n) begin
                    entry_reg <= WORD_ZERO;
                end else if (write_valid && (tail == 1'(gi))) begin
                    entry_reg <= write_data;
                end
            end
        end
    endgenerate

    always_comb begin
        count_next = count_reg;
        case ({write_valid, read_taken})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            count_reg <= COUNT_EMPTY;
            head_reg  <= 1'b0;
        end else begin
            count_reg <= count_next;
            if (read_taken) begin
                head_reg <= ~head_reg;
            end
        end
    end

    assign read_valid = (count_reg != COUNT_EMPTY);
    assign full       = (count_reg == COUNT_FULL);
    assign read_data  = head_reg ? g_entry[1].entry_reg : g_entry[0].entry_reg;

endmodule

// File: rtl/pulse_to_pipeline.sv
// pulse_to_pipeline
//   Captures single-cycle result pulses from a non-pipelined module into a
//   two-entry buffer and presents them on a ready/valid output. Each consumed
//   result emits a module_ready pulse so the upstream input wrapper can hand
//   the module its next input.
//
// Ports
//   clock                 : rising-edge clock
//   clear_n               : asynchronous active-low reset
//   module_data_out       : result word, sampled when module_data_out_valid=1
//   module_data_out_valid : one-cycle pulse marking a new result
//   module_ready          : one-cycle pulse, high when an output handshake completes
//   valid_out / ready_out / data_out : output handshake (head entry)
//   overflow              : sticky; a result arrived while full with no dequeue
//
// WORD_WIDTH must be 1 or more.
module pulse_to_pipeline #(
    parameter int WORD_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  clear_n,
    input  logic [WORD_WIDTH-1:0] module_data_out,
    input  logic                  module_data_out_valid,
    output logic                  module_ready,
    output logic                  valid_out,
    input  logic                  ready_out,
    output logic [WORD_WIDTH-1:0] data_out,
    output logic                  overflow
);

    logic full;
    logic enqueue;
    logic dequeue;
    logic overflow_reg;

    // valid_out comes straight from the registered count, so module_ready
    // has no path back through the connected module.
    assign dequeue      = valid_out & ready_out;
    assign enqueue      = module_data_out_valid & (~full | dequeue);
    assign module_ready = dequeue;

    two_entry_buffer #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_buffer (
        .clock       (clock),
        .clear_n     (clear_n),
        .write_valid (enqueue),
        .write_data  (module_data_out),
        .read_taken  (dequeue),
        .read_valid  (valid_out),
        .read_data   (data_out),
        .full        (full)
    );

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            overflow_reg <= 1'b0;
        end else if (module_data_out_valid && full && !dequeue) begin
            overflow_reg <= 1'b1;
        end
    end

    assign overflow = overflow_reg;

endmodule

// File: tb/tb_pulse_to_pipeline.sv
// tb_pulse_to_pipeline
//   Directed stimulus pushes expected words into a scoreboard queue; a
//   monitor on the falling edge pops and compares on every completed output
//   handshake. Additional directed checks cover reset, latency, module_ready
//   and overflow.
module tb_pulse_to_pipeline;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         clear_n = 1'b0;
    logic [W-1:0] module_data_out = '0;
    logic         module_data_out_valid = 1'b0;
    logic         module_ready;
    logic         valid_out;
    logic         ready_out = 1'b0;
    logic [W-1:0] data_out;
    logic         overflow;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q [$];

    pulse_to_pipeline #(.WORD_WIDTH(W)) dut (
        .clock                 (clock),
        .clear_n               (clear_n),
        .module_data_out       (module_data_out),
        .module_data_out_valid (module_data_out_valid),
        .module_ready          (module_ready),
        .valid_out             (valid_out),
        .ready_out             (ready_out),
        .data_out              (data_out),
        .overflow              (overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive a one-cycle result pulse; expected word is queued when accepted.
    task automatic pulse(input logic [W-1:0] word, input bit accepted);
        module_data_out       = word;
        module_data_out_valid = 1'b1;
        if (accepted) exp_q.push_back(word);
        tick();
        module_data_out_valid = 1'b0;
        $display("pulse 0x%02h accepted=%0d", word, accepted);
    endtask

    task automatic do_reset();
        clear_n = 1'b0;
        exp_q.delete();
        repeat (3) tick();
        clear_n = 1'b1;
        tick();
    endtask

    // Monitor: scoreboard compare on each completed handshake.
    always @(negedge clock) begin
        if (clear_n && valid_out) begin
            if (ready_out) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", {24'd0, data_out}, 32'hFFFF_FFFF);
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    chk("sb_data", {24'd0, data_out}, {24'd0, e});
                    $display("out 0x%02h expected 0x%02h", data_out, e);
                end
                chk("sb_module_ready_hi", {31'd0, module_ready}, 32'd1);
            end else begin
                chk("sb_module_ready_lo", {31'd0, module_ready}, 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1. Reset values
        repeat (3) tick();
        chk("rst_valid", {31'd0, valid_out}, 32'd0);
        chk("rst_data", {24'd0, data_out}, 32'd0);
        chk("rst_mready", {31'd0, module_ready}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        clear_n = 1'b1;
        tick();
        chk("post_rst_valid", {31'd0, valid_out}, 32'd0);

        // Asynchronous reset mid-cycle with a word buffered
        ready_out = 1'b0;
        pulse(8'h5A, 1'b1);
        chk("async_pre_valid", {31'd0, valid_out}, 32'd1);
        chk("async_pre_data", {24'd0, data_out}, 32'h5A);
        #2;
        clear_n = 1'b0;
        exp_q.delete();
        #1;
        chk("async_valid", {31'd0, valid_out}, 32'd0);
        chk("async_data", {24'd0, data_out}, 32'd0);
        tick();
        clear_n = 1'b1;
        tick();

        // 2. Single result, 1-cycle latency
        ready_out = 1'b1;
        pulse(8'hA5, 1'b1);
        chk("single_valid", {31'd0, valid_out}, 32'd1);
        chk("single_data", {24'd0, data_out}, 32'hA5);
        chk("single_mready", {31'd0, module_ready}, 32'd1);
        tick();
        chk("single_valid_after", {31'd0, valid_out}, 32'd0);
        chk("single_mready_after", {31'd0, module_ready}, 32'd0);

        // 3. Backpressure and ordering
        ready_out = 1'b0;
        pulse(8'h11, 1'b1);
        tick();
        pulse(8'h22, 1'b1);
        repeat (3) tick();
        chk("bp_valid", {31'd0, valid_out}, 32'd1);
        chk("bp_data_held", {24'd0, data_out}, 32'h11);
        chk("bp_mready", {31'd0, module_ready}, 32'd0);
        ready_out = 1'b1;
        #1;
        chk("bp_first", {24'd0, data_out}, 32'h11);
        chk("bp_first_mready", {31'd0, module_ready}, 32'd1);
        tick();
        chk("bp_second", {24'd0, data_out}, 32'h22);
        chk("bp_second_mready", {31'd0, module_ready}, 32'd1);
        tick();
        chk("bp_empty", {31'd0, valid_out}, 32'd0);

        // 4. Overflow
        ready_out = 1'b0;
        pulse(8'h01, 1'b1);
        pulse(8'h02, 1'b1);
        chk("ovf_before", {31'd0, overflow}, 32'd0);
        pulse(8'h03, 1'b0);
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        chk("ovf_head", {24'd0, data_out}, 32'h01);
        ready_out = 1'b1;
        repeat (2) tick();
        chk("ovf_drained", {31'd0, valid_out}, 32'd0);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);
        chk("ovf_sb_empty", exp_q.size(), 32'd0);
        do_reset();
        chk("ovf_cleared", {31'd0, overflow}, 32'd0);

        // 5. Full with simultaneous enqueue and dequeue
        ready_out = 1'b0;
        pulse(8'h01, 1'b1);
        pulse(8'h02, 1'b1);
        ready_out = 1'b1;
        #1;
        chk("fs_mready", {31'd0, module_ready}, 32'd1);
        pulse(8'h03, 1'b1);
        chk("fs_overflow", {31'd0, overflow}, 32'd0);
        chk("fs_data2", {24'd0, data_out}, 32'h02);
        tick();
        chk("fs_data3", {24'd0, data_out}, 32'h03);
        tick();
        chk("fs_empty", {31'd0, valid_out}, 32'd0);
        chk("fs_sb_empty", exp_q.size(), 32'd0);

        // 6. Loop closure: the input wrapper issues only after module_ready;
        //    the iterative module answers 4 cycles later with x*3+1.
        for (int i = 0; i < 16; i++) begin
            logic [W-1:0] res;
            bit consumed;
            res = W'(i * 3 + 1);
            chk("loop_no_unconsumed", {31'd0, valid_out}, 32'd0);
            for (int c = 0; c < 4; c++) begin
                ready_out = 1'($urandom_range(0, 1));
                tick();
            end
            pulse(res, 1'b1);
            consumed = 1'b0;
            for (int c = 0; c < 60 && !consumed; c++) begin
                ready_out = 1'($urandom_range(0, 1));
                #1;
                if (module_ready) consumed = 1'b1;
                tick();
            end
            chk("loop_consumed", {31'd0, consumed}, 32'd1);
        end
        ready_out = 1'b0;
        tick();
        chk("loop_overflow", {31'd0, overflow}, 32'd0);
        chk("loop_sb_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
